// File: rtl/dual_port_ram_arbiter.sv
// Shares one external dual-port RAM among several clients. The write port and the
// read port each have their own round-robin arbiter. Read data comes back registered,
// with a one-hot valid strobe, one cycle after the grant.
module dual_port_ram_arbiter #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int unsigned REQUESTERS    = 2
) (
    input  logic                                  clock,
    input  logic                                  resetn,
    input  logic [REQUESTERS-1:0]                 write_request,
    output logic [REQUESTERS-1:0]                 write_grant,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   write_address,
    input  logic [REQUESTERS*WIDTH-1:0]           write_data,
    input  logic [REQUESTERS-1:0]                 read_request,
    output logic [REQUESTERS-1:0]                 read_grant,
    input  logic [REQUESTERS*ADDRESS_WIDTH-1:0]   read_address,
    output logic [REQUESTERS-1:0]                 read_response_valid,
    output logic [WIDTH-1:0]                      read_response_data,
    output logic                                  ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0]              ram_write_address,
    output logic [WIDTH-1:0]                      ram_write_data,
    output logic                                  ram_read_enable,
    output logic [ADDRESS_WIDTH-1:0]              ram_read_address,
    input  logic [WIDTH-1:0]                      ram_read_data
);

    localparam int unsigned PTR_WIDTH = $clog2(REQUESTERS);
    typedef logic [PTR_WIDTH-1:0] ptr_t;

    ptr_t                  write_ptr_q, write_ptr_d;
    ptr_t                  read_ptr_q, read_ptr_d;
    logic [REQUESTERS-1:0] read_response_valid_q;
    logic [WIDTH-1:0]      read_response_data_q;

    // First active request at or above the pointer, wrapping around, wins.
    function automatic logic [REQUESTERS-1:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                                      input ptr_t ptr);
        logic [REQUESTERS-1:0] grant;
        logic                  found;
        int unsigned           idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < REQUESTERS; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= REQUESTERS) idx = idx - REQUESTERS;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

    // Pointer moves to one past the granted client; holds when nothing was granted.
    function automatic ptr_t rr_advance(input logic [REQUESTERS-1:0] grant, input ptr_t ptr);
        ptr_t nxt;
        nxt = ptr;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (grant[i]) nxt = (i + 1 == REQUESTERS) ? '0 : ptr_t'(i + 1);
        end
        return nxt;
    endfunction

    // Grant decode and next pointer for both sides.
    always_comb begin
        write_grant = rr_pick(write_request, write_ptr_q);
        read_grant  = rr_pick(read_request, read_ptr_q);
        write_ptr_d = rr_advance(write_grant, write_ptr_q);
        read_ptr_d  = rr_advance(read_grant, read_ptr_q);
    end

    // Route the granted client's address/data to the RAM; all zero without a grant.
    always_comb begin
        ram_write_address = '0;
        ram_write_data    = '0;
        ram_read_address  = '0;
        for (int unsigned i = 0; i < REQUESTERS; i++) begin
            if (write_grant[i]) begin
                ram_write_address = write_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                ram_write_data    = write_data[i*WIDTH +: WIDTH];
            end
            if (read_grant[i]) begin
                ram_read_address = read_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
        end
    end

    assign ram_write_enable = |write_grant;
    assign ram_read_enable  = |read_grant;

    // Arbitration pointers, independent per side.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            write_ptr_q <= '0;
            read_ptr_q  <= '0;
        end else begin
            write_ptr_q <= write_ptr_d;
            read_ptr_q  <= read_ptr_d;
        end
    end

    // Read response: valid follows the grant by one cycle; data holds between reads.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_response_valid_q <= '0;
            read_response_data_q  <= '0;
        end else begin
            read_response_valid_q <= read_grant;
            if (ram_read_enable) read_response_data_q <= ram_read_data;
        end
    end

    assign read_response_valid = read_response_valid_q;
    assign read_response_data  = read_response_data_q;

endmodule

// File: doc/dual_port_ram_arbiter.md
Name: dual_port_ram_arbiter

Overview:
- Shares one dual_port_ram instance among REQUESTERS clients.
- Two independent round-robin arbiters: one drives the RAM write port, one drives the RAM read port.
- Read data is registered and returned to the winning requester with a response-valid strobe one cycle after the grant.
- Sits between client logic (DMA, CPU-side bridges) and the RAM; the RAM itself is instantiated outside this block.

Parameters:
- WIDTH, 8, data width; must match the RAM.
- DEPTH, 16, RAM depth in words.
- ADDRESS_WIDTH, CLOG2(DEPTH), address width.
- REQUESTERS, 2, number of clients; must be 2 or more.

Ports:
- clock  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- write_request  input  REQUESTERS  per-client write request
- write_grant  output  REQUESTERS  one-hot write grant; write occurs when request and grant are both high
- write_address  input  REQUESTERS*ADDRESS_WIDTH  flattened per-client write addresses; client i uses slice i
- write_data  input  REQUESTERS*WIDTH  flattened per-client write data
- read_request  input  REQUESTERS  per-client read request
- read_grant  output  REQUESTERS  one-hot read grant
- read_address  input  REQUESTERS*ADDRESS_WIDTH  flattened per-client read addresses
- read_response_valid  output  REQUESTERS  one-hot; high for one cycle, the cycle after a read grant
- read_response_data  output  WIDTH  registered read data; shared by all clients
- ram_write_enable  output  1  to RAM write_enable
- ram_write_address  output  ADDRESS_WIDTH  to RAM write_address
- ram_write_data  output  WIDTH  to RAM write_data
- ram_read_enable  output  1  to RAM read_enable
- ram_read_address  output  ADDRESS_WIDTH  to RAM read_address
- ram_read_data  input  WIDTH  from RAM read_data; combinational read

Behaviour:
- Clock and reset: single clock; resetn is asynchronous assert, active low.
- Reset values: both priority pointers = 0; read_response_valid = 0; read_response_data = 0.
  - Grants and RAM-side outputs are combinational, so they are 0 whenever no request is present.
- Grant, per side:
  - Combinational, same cycle as the request.
  - Search starts at the priority pointer and goes upward with wrap-around; the first active request wins.
  - At most one grant bit is high.
  - Grant is 0 when no request is active.
- Pointer update:
  - On each clock edge where a grant was issued, that side's pointer becomes (granted index + 1) mod REQUESTERS.
  - With no grant, the pointer holds.
  - The write and read pointers are fully independent.
- Handshake:
  - A request may be held any number of cycles; the client keeps address and data stable until granted.
  - Request and grant both high in a cycle = transfer accepted at that edge.
  - A client keeping its request high after a grant starts a new transaction; it is not re-granted while other clients are requesting (round-robin).
- Write path:
  - ram_write_enable = OR of write_grant.
  - ram_write_address and ram_write_data are muxed from the granted slice; 0 when there is no grant.
  - The RAM is written at the edge.
- Read path:
  - ram_read_enable = OR of read_grant; ram_read_address is muxed from the granted slice.
  - At the edge, read_response_data <= ram_read_data and read_response_valid <= read_grant.
  - Latency is 1 cycle: grant in cycle N, response in cycle N+1.
- read_response_data hold: the data register holds its value when no read is granted; only read_response_valid falls back to 0.
- Back-to-back reads: a response every cycle is supported, giving full throughput.
- Same-address collision: a write and a read to the same address in the same cycle return the OLD data (read before write). The new data is visible to reads granted from the next cycle on.
- Independent sides: a client may hold write and read grants simultaneously.
- Reset mid-operation: an in-flight read response is dropped (valid forced to 0) and pointers return to 0. No state survives reset, and RAM contents are not this block's concern.
- Sizing: no internal FIFOs; no backpressure on responses (clients must accept read_response_valid unconditionally).

Test Plan:
Setup for all scenarios: REQUESTERS=3, WIDTH=8, DEPTH=16, RAM instantiated alongside.
- Reset: assert resetn=0 with random requests toggling -> read_response_valid=0 and read_response_data=0x00; after release with no requests, all grants and ram_* outputs are 0.
- Basic transfer: client 1 writes addr 5 data 0xA5; next cycle client 2 reads addr 5 -> read_grant=3'b100 in the same cycle; following cycle read_response_valid=3'b100 and read_response_data=0xA5.
- Fairness: all three clients hold write_request for 6 cycles -> write_grant sequence 001,010,100,001,010,100; the read side does the same independently and concurrently.
- Collision: addr 3 holds 0x22; in the same cycle client 0 writes 0x11 to addr 3 and client 1 reads addr 3 -> response 0x22; a read the next cycle returns 0x11.
- Pointer skip: after a grant to client 0 (pointer=1), only client 0 requests -> client 0 granted immediately. Then clients 0 and 2 request -> client 2 granted (pointer=1 searches 1,2,0).
- Reset mid-read: read granted in cycle N, resetn low before edge N+1 -> read_response_valid stays 0. After release, simultaneous requests from all clients -> client 0 granted first.
